lsu_dmem_master: RTL and testbench

- Load/store unit on the core side of the data-memory interface. It converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the word-only data memory.
- The memory has a combinational read (mem_rd is valid in the same cycle as mem_a), a synchronous write on mem_we, and no byte enables.
- Sub-word stores are therefore done as read-modify-write. The unit also flags misaligned, illegal-funct3 and out-of-range accesses.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane.sv | 47 ++++
 rtl/lsu_dmem_master.sv | 107 ++++++++++
 tb/tb_lsu_dmem_master.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding
// and the default data-memory depth.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int DMEM_WORDS_DEF = 256;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: extracts and extends load data from a memory word, and
// merges sub-word store data into the old word for read-modify-write.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  byte_off,
   input  logic [2:0]  funct3,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [4:0]  shamt;
   logic [31:0] byte_mask;

   assign shamt     = {byte_off, 3'b000};
   assign byte_sel  = 8'(word >> shamt);
   assign half_sel  = byte_off[1] ? word[31:16] : word[15:0];
   assign byte_mask = 32'h0000_00ff << shamt;

   always_comb begin
      load_data = 32'd0;
      case (funct3)
         F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  load_data = {24'd0, byte_sel};
         F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  load_data = {16'd0, half_sel};
         F3_LW:   load_data = word;
         default: load_data = 32'd0;
      endcase
   end

   // Only the addressed lane takes new data; the others keep the old word.
   always_comb begin
      merge_data = wdata;
      case (funct3)
         F3_SB:   merge_data = (word & ~byte_mask) | ({24'd0, wdata[7:0]} << shamt);
         F3_SH:   merge_data = byte_off[1] ? {wdata[15:0], word[15:0]}
                                           : {word[31:16], wdata[15:0]};
         default: merge_data = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store unit driving a word-only data memory with combinational read;
// sub-word stores are done as read-modify-write.
module lsu_dmem_master
   import lsu_pkg::*;
#(
   parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_WORDS);

   state_t      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [2:0]  f3_q;
   logic        we_q;
   logic        err_q;
   logic [31:0] load_word;
   logic [31:0] merge_word;

   function automatic logic req_fault(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr);
      logic bad_f3;
      logic misal;
      logic oor;
      if (we)
         bad_f3 = (f3 > F3_SW);
      else
         bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      misal = (((f3 == F3_LH) || (f3 == F3_LHU)) && addr[0]) ||
              ((f3 == F3_LW) && (addr[1:0] != 2'b00));
      oor   = ({2'b00, addr[31:2]} >= DMEM_LIMIT);
      return bad_f3 || misal || oor;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         f3_q    <= 3'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  f3_q    <= req_funct3;
                  we_q    <= req_we;
                  err_q   <= req_fault(req_we, req_funct3, req_addr);
                  if (req_fault(req_we, req_funct3, req_addr))
                     state <= RESP;
                  else if (req_we && (req_funct3 == F3_SW))
                     state <= WRITE;
                  else
                     state <= READ;
               end
            end
            // Old word is kept for both the load result and the store merge.
            READ: begin
               rdata_q <= mem_rd;
               state   <= we_q ? WRITE : RESP;
            end
            WRITE:   state <= RESP;
            default: state <= IDLE;
         endcase
      end
   end

   lsu_lane u_lane (
      .word       (rdata_q),
      .wdata      (wdata_q),
      .byte_off   (addr_q[1:0]),
      .funct3     (f3_q),
      .load_data  (load_word),
      .merge_data (merge_word)
   );

   // Outputs decode straight from registered state, so reset clears them at once.
   assign req_ready  = (state == IDLE);
   assign mem_a      = {addr_q[31:2], 2'b00};
   assign mem_we     = (state == WRITE);
   assign mem_wd     = (state == WRITE) ? merge_word : 32'd0;
   assign resp_valid = (state == RESP);
   assign resp_err   = (state == RESP) && err_q;
   assign resp_rdata = ((state == RESP) && !we_q && !err_q) ? load_word : 32'd0;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master with a word memory model and
// hand-computed expected results.
module tb_lsu_dmem_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic [31:0] mem_rd;

   logic [31:0] mem [0:255];
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lsu_dmem_master #(.DMEM_WORDS(256)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd)
   );

   assign mem_rd = mem[mem_a[9:2]];

   always @(posedge clk) begin
      if (mem_we)
         mem[mem_a[9:2]] <= mem_wd;
      else if (pre_we)
         mem[pre_idx] <= pre_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      pre_idx  = idx;
      pre_data = data;
      pre_we   = 1'b1;
      @(posedge clk); #1;
      pre_we   = 1'b0;
   endtask

   // Issue one request and follow it to its response pulse.
   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_wes,
                         input logic [31:0] exp_wd);
      int lat;
      int wes;
      logic [31:0] wd_seen;
      check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      lat = 1;
      wes = 0;
      wd_seen = 32'd0;
      while (!resp_valid && lat < 8) begin
         if (mem_we) begin
            wes++;
            wd_seen = mem_wd;
         end
         @(posedge clk); #1;
         lat++;
      end
      if (mem_we) wes++;
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, resp_rdata, exp_rdata);
      check({tag, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
      check({tag, " we cycles"}, 32'(wes), 32'(exp_wes));
      if (exp_wes > 0)
         check({tag, " mem_wd"}, wd_seen, exp_wd);
      @(posedge clk); #1;
      check({tag, " pulse end"}, {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin
      bit saw_resp;
      bit saw_we;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      pre_we     = 1'b0;
      pre_idx    = 8'd0;
      pre_data   = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst ready", {31'd0, req_ready}, 32'd1);
      check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst resp_err", {31'd0, resp_err}, 32'd0);
      check("rst resp_rdata", resp_rdata, 32'd0);
      check("rst mem_a", mem_a, 32'd0);
      check("rst mem_wd", mem_wd, 32'd0);
      check("rst mem_we", {31'd0, mem_we}, 32'd0);
      reset = 1'b0;

      preload(8'd4, 32'h8899_AABB);
      preload(8'd2, 32'h1122_3344);
      preload(8'd8, 32'hCAFE_F00D);

      // Loads
      do_req("LW 10",  1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h8899_AABB, 1'b0, 0, 32'h0);
      do_req("LB 13",  1'b0, 3'b000, 32'h13, 32'h0, 2, 32'hFFFF_FF88, 1'b0, 0, 32'h0);
      do_req("LBU 13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 32'h0000_0088, 1'b0, 0, 32'h0);
      do_req("LH 12",  1'b0, 3'b001, 32'h12, 32'h0, 2, 32'hFFFF_8899, 1'b0, 0, 32'h0);
      do_req("LHU 10", 1'b0, 3'b101, 32'h10, 32'h0, 2, 32'h0000_AABB, 1'b0, 0, 32'h0);
      do_req("LB 10",  1'b0, 3'b000, 32'h10, 32'h0, 2, 32'hFFFF_FFBB, 1'b0, 0, 32'h0);

      // Sub-word stores
      do_req("SB 09", 1'b1, 3'b000, 32'h09, 32'hFFFF_FFA5, 3, 32'h0, 1'b0, 1, 32'h1122_A544);
      check("SB 09 mem", mem[2], 32'h1122_A544);
      do_req("SH 0A", 1'b1, 3'b001, 32'h0A, 32'h0000_BEEF, 3, 32'h0, 1'b0, 1, 32'hBEEF_A544);
      check("SH 0A mem", mem[2], 32'hBEEF_A544);
      do_req("LW 08", 1'b0, 3'b010, 32'h08, 32'h0, 2, 32'hBEEF_A544, 1'b0, 0, 32'h0);

      // Error cases
      do_req("SW 06 misal",   1'b1, 3'b010, 32'h06,  32'hDEAD_BEEF, 1, 32'h0, 1'b1, 0, 32'h0);
      do_req("LH 03 misal",   1'b0, 3'b001, 32'h03,  32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
      do_req("LD f3 011",     1'b0, 3'b011, 32'h00,  32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
      do_req("SB f3 100",     1'b1, 3'b100, 32'h00,  32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
      do_req("LW 400 range",  1'b0, 3'b010, 32'h400, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
      do_req("LW 3FC inrange",1'b0, 3'b010, 32'h3FC, 32'h0, 2, mem[255], 1'b0, 0, 32'h0);

      // Reset while the SB is in READ
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h20;
      req_wdata  = 32'h0000_0055;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      check("rmid in read", {31'd0, req_ready}, 32'd0);
      reset = 1'b1;
      #1;
      check("rmid ready", {31'd0, req_ready}, 32'd1);
      check("rmid mem_we", {31'd0, mem_we}, 32'd0);
      check("rmid resp_valid", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      saw_resp = 1'b0;
      saw_we   = 1'b0;
      repeat (4) begin
         if (resp_valid) saw_resp = 1'b1;
         if (mem_we) saw_we = 1'b1;
         @(posedge clk); #1;
      end
      check("rmid no resp", {31'd0, saw_resp}, 32'd0);
      check("rmid no we", {31'd0, saw_we}, 32'd0);
      check("rmid mem8", mem[8], 32'hCAFE_F00D);
      do_req("LW 20 after", 1'b0, 3'b010, 32'h20, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 0, 32'h0);

      // Back-to-back with req_valid held high
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h00;
      req_wdata  = 32'h1234_5678;
      @(posedge clk); #1;
      req_we     = 1'b0;
      req_wdata  = 32'h0;
      check("b2b c1 we", {31'd0, mem_we}, 32'd1);
      check("b2b c1 wd", mem_wd, 32'h1234_5678);
      check("b2b c1 ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      check("b2b c2 resp", {31'd0, resp_valid}, 32'd1);
      check("b2b c2 err", {31'd0, resp_err}, 32'd0);
      check("b2b c2 rdata", resp_rdata, 32'd0);
      @(posedge clk); #1;
      check("b2b c3 ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("b2b c4 ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      check("b2b c5 resp", {31'd0, resp_valid}, 32'd1);
      check("b2b c5 rdata", resp_rdata, 32'h1234_5678);
      check("b2b c5 err", {31'd0, resp_err}, 32'd0);
      @(posedge clk); #1;
      check("b2b idle", {31'd0, req_ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
